// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wr_arbiter: round-robin share of the regfile write port among    |
// | ALU (0), load (1) and debug/host (2), with saturating grant/conflict     |
// | counters.                                                                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [2:0]        Req,
  input  logic [ADDR_W-1:0] ReqRW0,
  input  logic [ADDR_W-1:0] ReqRW1,
  input  logic [ADDR_W-1:0] ReqRW2,
  input  logic [DATA_W-1:0] ReqData0,
  input  logic [DATA_W-1:0] ReqData1,
  input  logic [DATA_W-1:0] ReqData2,
  output logic [2:0]        Ack,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  output logic              RegWr,
  output logic [CNT_W-1:0]  GrantCnt,
  output logic [CNT_W-1:0]  ConflictCnt
);

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2
  } ptr_t;

  ptr_t              ptr;
  logic [2:0]        grant;
  logic [ADDR_W-1:0] win_rw;
  logic [DATA_W-1:0] win_data;
  ptr_t              next_ptr;
  logic              conflict;

  // Ptr names the highest-priority requester; search wraps Ptr, Ptr+1, Ptr+2.
  always_comb begin
    grant = 3'b000;
    if (!Reset) begin
      case (ptr)
        P0: begin
          if      (Req[0]) grant = 3'b001;
          else if (Req[1]) grant = 3'b010;
          else if (Req[2]) grant = 3'b100;
        end
        P1: begin
          if      (Req[1]) grant = 3'b010;
          else if (Req[2]) grant = 3'b100;
          else if (Req[0]) grant = 3'b001;
        end
        P2: begin
          if      (Req[2]) grant = 3'b100;
          else if (Req[0]) grant = 3'b001;
          else if (Req[1]) grant = 3'b010;
        end
        default: grant = 3'b000;
      endcase
    end
  end

  always_comb begin
    win_rw   = '0;
    win_data = '0;
    next_ptr = ptr;
    case (grant)
      3'b001: begin
        win_rw   = ReqRW0;
        win_data = ReqData0;
        next_ptr = P1;
      end
      3'b010: begin
        win_rw   = ReqRW1;
        win_data = ReqData1;
        next_ptr = P2;
      end
      3'b100: begin
        win_rw   = ReqRW2;
        win_data = ReqData2;
        next_ptr = P0;
      end
      default: ;
    endcase
  end

  assign conflict = (Req[0] & Req[1]) | (Req[0] & Req[2]) | (Req[1] & Req[2]);
  assign Ack      = grant;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr         <= P0;
      RW          <= '0;
      BusW        <= '0;
      RegWr       <= 1'b0;
      GrantCnt    <= '0;
      ConflictCnt <= '0;
    end else begin
      ptr   <= next_ptr;
      RegWr <= 1'b0;
      // A grant targeting R0 is acknowledged but never reaches the regfile.
      if (grant != 3'b000 && win_rw != '0) begin
        RW    <= win_rw;
        BusW  <= win_data;
        RegWr <= 1'b1;
      end
      if (grant != 3'b000 && GrantCnt != '1)
        GrantCnt <= GrantCnt + 1'b1;
      if (conflict && ConflictCnt != '1)
        ConflictCnt <= ConflictCnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// Bench for regfile_wr_arbiter: directed scenarios then randomized traffic,
// checked against a rule-level model of arbitration, counters and regfile.
module tb_regfile_wr_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [2:0]  Req;
  logic [4:0]  ReqRW0, ReqRW1, ReqRW2;
  logic [31:0] ReqData0, ReqData1, ReqData2;

  logic [2:0]  Ack,   Ack4;
  logic [4:0]  RW,    RW4;
  logic [31:0] BusW,  BusW4;
  logic        RegWr, RegWr4;
  logic [15:0] GrantCnt, ConflictCnt;
  logic [3:0]  GrantCnt4, ConflictCnt4;

  always #5 Clk = ~Clk;

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .ReqRW0(ReqRW0), .ReqRW1(ReqRW1), .ReqRW2(ReqRW2),
    .ReqData0(ReqData0), .ReqData1(ReqData1), .ReqData2(ReqData2),
    .Ack(Ack), .RW(RW), .BusW(BusW), .RegWr(RegWr),
    .GrantCnt(GrantCnt), .ConflictCnt(ConflictCnt)
  );

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .ReqRW0(ReqRW0), .ReqRW1(ReqRW1), .ReqRW2(ReqRW2),
    .ReqData0(ReqData0), .ReqData1(ReqData1), .ReqData2(ReqData2),
    .Ack(Ack4), .RW(RW4), .BusW(BusW4), .RegWr(RegWr4),
    .GrantCnt(GrantCnt4), .ConflictCnt(ConflictCnt4)
  );

  // Register file fed by the primary instance; writes land on negedge.
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(negedge Clk) if (RegWr && RW != 5'd0) rf[RW] <= BusW;

  // Reference model state
  int          m_ptr, m_g, m_c;
  logic [4:0]  m_rw;
  logic [31:0] m_busw;
  logic        m_regwr;
  logic [31:0] mrf [32];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] rw_of(input int i);
    return (i == 0) ? ReqRW0 : (i == 1) ? ReqRW1 : ReqRW2;
  endfunction

  function automatic logic [31:0] data_of(input int i);
    return (i == 0) ? ReqData0 : (i == 1) ? ReqData1 : ReqData2;
  endfunction

  function automatic logic [2:0] model_ack(input logic rst, input logic [2:0] rq);
    if (rst) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (rq[i]) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_update(input logic rst, input logic [2:0] rq, input logic [2:0] ack);
    if (rst) begin
      m_ptr = 0; m_rw = '0; m_busw = '0; m_regwr = 1'b0; m_g = 0; m_c = 0;
    end else begin
      if ($countones(rq) >= 2) m_c++;
      m_regwr = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (ack[i]) begin
          m_g++;
          m_ptr = (i + 1) % 3;
          if (rw_of(i) != 5'd0) begin
            m_rw = rw_of(i); m_busw = data_of(i); m_regwr = 1'b1;
            mrf[m_rw] = m_busw;
          end
        end
      end
    end
  endtask

  // One cycle: inputs driven just after posedge, Ack and regfile checked after
  // negedge, registered outputs checked just after the next posedge.
  task automatic step(input logic rst, input logic [2:0] rq, output logic [2:0] got_ack);
    logic [2:0] e_ack;
    logic       rf_ok;
    Reset = rst;
    Req   = rq;
    e_ack = model_ack(rst, rq);
    @(negedge Clk); #1;
    got_ack = Ack;
    chk("ack", 64'(Ack), 64'(e_ack));
    chk("ack_cnt4", 64'(Ack4), 64'(e_ack));
    rf_ok = 1'b1;
    for (int i = 0; i < 32; i++) if (rf[i] !== mrf[i]) rf_ok = 1'b0;
    chk("regfile", 64'(rf_ok), 64'(1));
    @(posedge Clk); #1;
    model_update(rst, rq, e_ack);
    chk("regwr", 64'(RegWr), 64'(m_regwr));
    chk("rw", 64'(RW), 64'(m_rw));
    chk("busw", 64'(BusW), 64'(m_busw));
    chk("grantcnt", 64'(GrantCnt), 64'(sat(m_g, 65535)));
    chk("conflictcnt", 64'(ConflictCnt), 64'(sat(m_c, 65535)));
    chk("grantcnt4", 64'(GrantCnt4), 64'(sat(m_g, 15)));
    chk("conflictcnt4", 64'(ConflictCnt4), 64'(sat(m_c, 15)));
  endtask

  logic [2:0] a;
  logic [2:0] seq [6];
  logic [2:0] pend;

  initial begin
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    m_ptr = 0; m_g = 0; m_c = 0; m_rw = '0; m_busw = '0; m_regwr = 1'b0;
    Reset = 1'b1; Req = 3'b000;
    ReqRW0 = 5'd1; ReqRW1 = 5'd2; ReqRW2 = 5'd3;
    ReqData0 = 32'h11; ReqData1 = 32'h22; ReqData2 = 32'h33;
    @(posedge Clk); #1;

    // Reset held with all requests pending
    step(1'b1, 3'b111, a);
    chk("reset_ack0", 64'(a), 64'(0));
    step(1'b1, 3'b111, a);
    chk("reset_ack1", 64'(a), 64'(0));
    step(1'b0, 3'b000, a);
    chk("reset_cnt", 64'(GrantCnt), 64'(0));

    // Single request from the load path
    ReqRW1 = 5'd5; ReqData1 = 32'hDEADBEEF;
    step(1'b0, 3'b010, a);
    chk("single_ack", 64'(a), 64'(3'b010));
    chk("single_rw", 64'(RW), 64'(5));
    chk("single_busw", 64'(BusW), 64'(32'hDEADBEEF));
    step(1'b0, 3'b000, a);
    chk("single_rf5", 64'(rf[5]), 64'(32'hDEADBEEF));

    // Round robin from reset under full contention
    step(1'b1, 3'b000, a);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 3'b111, a);
      seq[k] = a;
    end
    chk("rr0", 64'(seq[0]), 64'(3'b001));
    chk("rr1", 64'(seq[1]), 64'(3'b010));
    chk("rr2", 64'(seq[2]), 64'(3'b100));
    chk("rr3", 64'(seq[3]), 64'(3'b001));
    chk("rr4", 64'(seq[4]), 64'(3'b010));
    chk("rr5", 64'(seq[5]), 64'(3'b100));
    chk("rr_conflict", 64'(ConflictCnt), 64'(6));
    chk("rr_grant", 64'(GrantCnt), 64'(6));

    // Write to R0 is acknowledged and dropped
    ReqRW0 = 5'd0; ReqData0 = 32'h1234;
    step(1'b0, 3'b001, a);
    chk("r0_ack", 64'(a), 64'(3'b001));
    chk("r0_regwr", 64'(RegWr), 64'(0));
    step(1'b0, 3'b000, a);
    chk("r0_rf", 64'(rf[0]), 64'(0));

    // Same target from two requesters, starting at P0
    step(1'b1, 3'b000, a);
    ReqRW0 = 5'd7; ReqData0 = 32'hA; ReqRW2 = 5'd7; ReqData2 = 32'hB;
    step(1'b0, 3'b101, a);
    chk("same_first", 64'(a), 64'(3'b001));
    step(1'b0, 3'b100, a);
    chk("same_second", 64'(a), 64'(3'b100));
    step(1'b0, 3'b000, a);
    chk("same_r7", 64'(rf[7]), 64'(32'hB));

    // Reset the cycle after an acknowledged write
    ReqRW1 = 5'd9; ReqData1 = 32'h5A5A;
    step(1'b0, 3'b010, a);
    step(1'b1, 3'b010, a);
    chk("midrst_regwr", 64'(RegWr), 64'(0));
    step(1'b0, 3'b000, a);

    // Counter saturation on the narrow instance
    step(1'b1, 3'b000, a);
    for (int k = 0; k < 20; k++) step(1'b0, 3'b111, a);
    chk("sat_conflict4", 64'(ConflictCnt4), 64'(15));
    chk("sat_grant4", 64'(GrantCnt4), 64'(15));
    chk("sat_conflict16", 64'(ConflictCnt), 64'(20));

    // Randomized traffic; each requester holds its write until acknowledged
    pend = 3'b000;
    a    = 3'b000;
    for (int n = 0; n < 300; n++) begin
      logic r;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] || a[i]) begin
          pend[i] = ($urandom_range(0, 2) != 0);
          if (i == 0) begin ReqRW0 = 5'($urandom_range(0, 31)); ReqData0 = $urandom; end
          if (i == 1) begin ReqRW1 = 5'($urandom_range(0, 31)); ReqData1 = $urandom; end
          if (i == 2) begin ReqRW2 = 5'($urandom_range(0, 31)); ReqData2 = $urandom; end
        end
      end
      r = ($urandom_range(0, 49) == 0);
      step(r, pend, a);
    end
    step(1'b0, 3'b000, a);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
